rx_dma_src_arbiter: RTL and testbench

Frame-granular arbiter that shares the single 64-bit RX S2MM DMA stream between two packet-framed sources. Source 0 is the WiFi RX packet path; source 1 is the IQ capture path. It sits between those producers and the m_axis stream FIFO. It grants one whole frame at a time, counts words, generates tlast and the start-of-transfer pulse, and aborts frames whose source stalls.

---
 rtl/rx_dma_src_arbiter_if.sv | 13 +
 rtl/rx_dma_src_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_rx_dma_src_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_dma_src_arbiter_if.sv
// rtl/rx_dma_src_arbiter_if.sv - stream output bundle of the RX DMA source arbiter
// master drives the DMA stream, slave is the downstream FIFO side.
interface rx_dma_src_arbiter_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_last;
  logic                  m_start;

  modport master (output m_data, output m_valid, output m_last, output m_start);
  modport slave  (input  m_data, input  m_valid, input  m_last, input  m_start);
endinterface

// File: rtl/rx_dma_src_arbiter.sv
// rtl/rx_dma_src_arbiter.sv - frame-granular two-source arbiter onto the RX S2MM DMA stream
// Optional tag word prefix per frame: define RX_DMA_ARB_FRAME_TAG_EN.
module rx_dma_src_arbiter #(
  parameter int DATA_WIDTH    = 64,
  parameter int LEN_WIDTH     = 14,
  parameter int TIMEOUT_WIDTH = 13
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     src0_req,
  input  logic                     src1_req,
  input  logic [LEN_WIDTH-1:0]     src0_len,
  input  logic [LEN_WIDTH-1:0]     src1_len,
  input  logic [DATA_WIDTH-1:0]    src0_data,
  input  logic [DATA_WIDTH-1:0]    src1_data,
  input  logic                     src0_valid,
  input  logic                     src1_valid,
  output logic                     src0_grant,
  output logic                     src1_grant,
  input  logic                     fixed_prio,
  input  logic                     timeout_en,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_top,
  input  logic                     tsf_pulse_1M,
  input  logic [31:0]              tsf_lo,
  rx_dma_src_arbiter_if.master     m_axis,
  output logic                     abort_pulse,
  output logic                     busy,
  output logic                     cur_src
);

`ifdef RX_DMA_ARB_FRAME_TAG_EN
  typedef enum logic [2:0] {IDLE, TAG, XFER, ABORT, GAP} state_e;
`else
  typedef enum logic [2:0] {IDLE, XFER, ABORT, GAP} state_e;
`endif

  state_e                  state_q, state_d;
  logic [1:0]              grant_q, grant_d;
  logic                    m_start_q, m_start_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic                    abort_q, abort_d;
  logic                    cur_src_q, cur_src_d;
  logic                    last_served_q, last_served_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;

`ifdef RX_DMA_ARB_FRAME_TAG_EN
  logic [31:0]             tsf_q, tsf_d;
`else
  logic                    unused_tsf_lo;
  assign unused_tsf_lo = ^tsf_lo;
`endif

  // Zero-length requests are masked; on a tie the source not served last wins.
  logic elig0, elig1, win1;
  assign elig0 = src0_req && (src0_len != '0);
  assign elig1 = src1_req && (src1_len != '0);
  assign win1  = elig1 && (!elig0 || (!fixed_prio && !last_served_q));

  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  assign sel_valid = cur_src_q ? src1_valid : src0_valid;
  assign sel_data  = cur_src_q ? src1_data  : src0_data;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      m_start_q     <= 1'b0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      m_data_q      <= '0;
      abort_q       <= 1'b0;
      cur_src_q     <= 1'b0;
      last_served_q <= 1'b1;
      len_q         <= '0;
      cnt_q         <= '0;
      timer_q       <= '0;
`ifdef RX_DMA_ARB_FRAME_TAG_EN
      tsf_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      m_start_q     <= m_start_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      m_data_q      <= m_data_d;
      abort_q       <= abort_d;
      cur_src_q     <= cur_src_d;
      last_served_q <= last_served_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
`ifdef RX_DMA_ARB_FRAME_TAG_EN
      tsf_q         <= tsf_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    m_start_d     = 1'b0;
    m_valid_d     = 1'b0;
    m_last_d      = 1'b0;
    m_data_d      = m_data_q;
    abort_d       = 1'b0;
    cur_src_d     = cur_src_q;
    last_served_d = last_served_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    timer_d       = timer_q;
`ifdef RX_DMA_ARB_FRAME_TAG_EN
    tsf_d         = tsf_q;
`endif
    case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          grant_d   = win1 ? 2'b10 : 2'b01;
          m_start_d = 1'b1;
          cur_src_d = win1;
          len_d     = win1 ? src1_len : src0_len;
          cnt_d     = '0;
          timer_d   = '0;
`ifdef RX_DMA_ARB_FRAME_TAG_EN
          tsf_d     = tsf_lo;
          state_d   = TAG;
`else
          state_d   = XFER;
`endif
        end
      end
`ifdef RX_DMA_ARB_FRAME_TAG_EN
      TAG: begin
        m_valid_d = 1'b1;
        m_data_d  = DATA_WIDTH'({cur_src_q, 15'd0, 16'(len_q), tsf_q});
        state_d   = XFER;
      end
`endif
      XFER: begin
        m_data_d = sel_data;
        // A stalled source is cut off even if its word arrives on the same cycle.
        if (timeout_en && (timer_q > timeout_top)) begin
          state_d = ABORT;
        end else if (sel_valid) begin
          m_valid_d = 1'b1;
          cnt_d     = cnt_q + LEN_WIDTH'(1);
          timer_d   = '0;
          if (cnt_q == len_q - LEN_WIDTH'(1)) begin
            m_last_d      = 1'b1;
            grant_d       = '0;
            last_served_d = cur_src_q;
            state_d       = GAP;
          end
        end else if (tsf_pulse_1M && (timer_q != '1)) begin
          timer_d = timer_q + TIMEOUT_WIDTH'(1);
        end
      end
      ABORT: begin
        m_data_d      = '0;
        m_valid_d     = 1'b1;
        m_last_d      = 1'b1;
        grant_d       = '0;
        abort_d       = 1'b1;
        last_served_d = cur_src_q;
        state_d       = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign src0_grant     = grant_q[0];
  assign src1_grant     = grant_q[1];
  assign m_axis.m_data  = m_data_q;
  assign m_axis.m_valid = m_valid_q;
  assign m_axis.m_last  = m_last_q;
  assign m_axis.m_start = m_start_q;
  assign abort_pulse    = abort_q;
  assign busy           = (state_q != IDLE);
  assign cur_src        = cur_src_q;

endmodule

// File: tb/tb_rx_dma_src_arbiter.sv
// tb/tb_rx_dma_src_arbiter.sv - randomized frame traffic against a queue-based arbiter model
// Tag-word checks follow RX_DMA_ARB_FRAME_TAG_EN.
module tb_rx_dma_src_arbiter;
  localparam int DW = 64;
  localparam int LW = 14;
  localparam int TW = 13;
`ifdef RX_DMA_ARB_FRAME_TAG_EN
  localparam int TAGW = 1;
`else
  localparam int TAGW = 0;
`endif

  typedef struct {
    int len;
    int nsend;
    int idle;
  } job_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [1:0]    req;
  logic [LW-1:0] len [2];
  logic [DW-1:0] data [2];
  logic [1:0]    valid;
  wire  [1:0]    gnt;
  logic          fixed_prio, timeout_en, tsf_pulse;
  logic [TW-1:0] timeout_top;
  logic [31:0]   tsf_lo;
  wire           abort_pulse, busy, cur_src;

  rx_dma_src_arbiter_if m_if ();

  rx_dma_src_arbiter dut (
    .clk(clk), .rstn(rstn),
    .src0_req(req[0]), .src1_req(req[1]),
    .src0_len(len[0]), .src1_len(len[1]),
    .src0_data(data[0]), .src1_data(data[1]),
    .src0_valid(valid[0]), .src1_valid(valid[1]),
    .src0_grant(gnt[0]), .src1_grant(gnt[1]),
    .fixed_prio(fixed_prio), .timeout_en(timeout_en), .timeout_top(timeout_top),
    .tsf_pulse_1M(tsf_pulse), .tsf_lo(tsf_lo),
    .m_axis(m_if),
    .abort_pulse(abort_pulse), .busy(busy), .cur_src(cur_src)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  job_t        jq [2][$];
  int          mlen [2][$];
  logic [64:0] expq [$];
  int          glog [$];
  int          mlast = 1;
  int          n_start = 0, n_valid = 0, n_last = 0, n_abort = 0;
  int          gcount [2] = '{0, 0};
  logic [63:0] first_word = '0;
  bit          act = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic add_job(input int n, input int l, input int ns, input int idl);
    job_t j;
    j.len = l; j.nsend = ns; j.idle = idl;
    jq[n].push_back(j);
    mlen[n].push_back(l);
  endtask

  task automatic drain(input string nm, input int budget);
    int c = 0;
    while ((jq[0].size() != 0 || jq[1].size() != 0 || expq.size() != 0 || busy || act) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_drain_timeout"}, 64'(c >= budget), 64'd0);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk({nm, "_grant"}, 64'(gnt), 64'd0);
    chk({nm, "_m_valid"}, 64'(m_if.m_valid), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_m_last"}, 64'(m_if.m_last), 64'd0);
    chk({nm, "_m_start"}, 64'(m_if.m_start), 64'd0);
    chk({nm, "_abort"}, 64'(abort_pulse), 64'd0);
    jq[0].delete(); jq[1].delete();
    mlen[0].delete(); mlen[1].delete();
    expq.delete();
    mlast = 1;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // 1 us tick every 10 cycles
  initial begin
    int tcnt = 0;
    tsf_pulse = 1'b0;
    forever begin
      @(posedge clk); #1;
      tcnt++;
      tsf_pulse = (tcnt % 10 == 0);
    end
  end

  // Source driver: serves whichever source holds the grant, one word per allowed cycle.
  initial begin
    job_t cj;
    int s = 0, k = 0, idle_left = 0;
    bit tag_wait = 0;
    req = '0; valid = '0;
    len[0] = '0; len[1] = '0; data[0] = '0; data[1] = '0;
    forever begin
      @(posedge clk); #1;
      valid = '0;
      if (!rstn) begin
        req = '0; act = 0;
        continue;
      end
      if (act && k >= cj.nsend && !gnt[s]) act = 0;
      if (!act) begin
        for (int n = 0; n < 2; n++) begin
          if (!act && gnt[n] && jq[n].size() != 0) begin
            cj = jq[n].pop_front();
            act = 1; s = n; k = 0;
            idle_left = $urandom_range(cj.idle);
            tag_wait = (TAGW != 0);
            if (TAGW != 0) expq.push_back({1'b0, (n == 1), 15'd0, 16'(cj.len), tsf_lo});
          end
        end
      end
      if (act && k < cj.nsend) begin
        if (tag_wait) tag_wait = 0;
        else if (idle_left > 0) idle_left--;
        else begin
          valid[s] = 1'b1;
          data[s]  = {$urandom, $urandom};
          expq.push_back({(k == cj.len - 1), data[s]});
          k++;
          idle_left = $urandom_range(cj.idle);
          if (k == cj.nsend && cj.nsend < cj.len) expq.push_back({1'b1, 64'd0});
        end
      end
      for (int n = 0; n < 2; n++) begin
        req[n] = (jq[n].size() != 0);
        len[n] = (jq[n].size() != 0) ? LW'(jq[n][0].len) : '0;
      end
    end
  end

  // Compare process: predicts each grant from pending requests and checks every output word.
  initial begin
    logic [1:0]  prev_g = '0;
    logic [64:0] e;
    int          stall = 0;
    bit          first_pending = 0;
    bit          e0, e1;
    int          w, cs;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_g = '0;
        continue;
      end
      chk("grant_excl", 64'(gnt == 2'b11), 64'd0);
      if (m_if.m_start) begin
        e0 = (mlen[0].size() != 0) && (mlen[0][0] != 0);
        e1 = (mlen[1].size() != 0) && (mlen[1][0] != 0);
        chk("start_eligible", 64'(e0 || e1), 64'd1);
        if (e0 && e1) w = fixed_prio ? 0 : 1 - mlast;
        else w = e1 ? 1 : 0;
        chk("grant_src", 64'(gnt), (w == 1) ? 64'd2 : 64'd1);
        chk("cur_src", 64'(cur_src), 64'(w));
        chk("grant_rise", 64'(prev_g), 64'd0);
        if (e0 || e1) begin
          void'(mlen[w].pop_front());
          mlast = w;
          glog.push_back(w);
          gcount[w]++;
        end
        n_start++;
        stall = 0;
        first_pending = 1;
      end
      if (m_if.m_valid) begin
        n_valid++;
        chk("word_pending", 64'(expq.size() != 0), 64'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("m_data", m_if.m_data, e[63:0]);
          chk("m_last", 64'(m_if.m_last), 64'(e[64]));
        end
        if (first_pending) first_word = m_if.m_data;
        first_pending = 0;
        if (m_if.m_last) begin
          n_last++;
          chk("grant_drop", 64'(gnt), 64'd0);
        end
      end else begin
        chk("m_last_idle", 64'(m_if.m_last), 64'd0);
      end
      if (abort_pulse) begin
        n_abort++;
        chk("stall_ticks", 64'(stall), 64'(timeout_top) + 64'd1);
      end
      if (gnt != 2'b00) begin
        chk("busy", 64'(busy), 64'd1);
        cs = gnt[1] ? 1 : 0;
        if (valid[cs]) stall = 0;
        else if (tsf_pulse) stall++;
      end
      prev_g = gnt;
    end
  end

  initial begin
    int b_start, b_valid, b_last, b_abort, b_g0, b_g1, c;
    fixed_prio = 1'b0; timeout_en = 1'b0; timeout_top = TW'(3); tsf_lo = 32'h1234_5678;
    repeat (3) @(negedge clk);
    chk("rst_grant", 64'(gnt), 64'd0);
    chk("rst_m_valid", 64'(m_if.m_valid), 64'd0);
    chk("rst_m_last", 64'(m_if.m_last), 64'd0);
    chk("rst_m_start", 64'(m_if.m_start), 64'd0);
    chk("rst_m_data", m_if.m_data, 64'd0);
    chk("rst_abort", 64'(abort_pulse), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cur_src", 64'(cur_src), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // round-robin tie, source 0 first after reset
    glog.delete();
    add_job(0, 2, 2, 0); add_job(0, 2, 2, 0);
    add_job(1, 2, 2, 0); add_job(1, 2, 2, 0);
    drain("rr", 400);
    chk("rr_count", 64'(glog.size()), 64'd4);
    if (glog.size() == 4) chk("rr_order", 64'(glog[0]*8 + glog[1]*4 + glog[2]*2 + glog[3]), 64'd5);

    // fixed priority: source 0 drains before source 1
    fixed_prio = 1'b1;
    glog.delete();
    add_job(0, 2, 2, 0); add_job(0, 2, 2, 0);
    add_job(1, 2, 2, 0); add_job(1, 2, 2, 0);
    drain("fixed", 400);
    chk("fixed_count", 64'(glog.size()), 64'd4);
    if (glog.size() == 4) chk("fixed_order", 64'(glog[0]*8 + glog[1]*4 + glog[2]*2 + glog[3]), 64'd3);
    fixed_prio = 1'b0;

    // single frame of three back-to-back words
    b_start = n_start; b_valid = n_valid; b_last = n_last;
    add_job(0, 3, 3, 0);
    drain("single", 200);
    chk("single_starts", 64'(n_start - b_start), 64'd1);
    chk("single_words", 64'(n_valid - b_valid), 64'(3 + TAGW));
    chk("single_lasts", 64'(n_last - b_last), 64'd1);

    // stall abort after the fourth idle tick
    timeout_en = 1'b1;
    b_abort = n_abort; b_valid = n_valid;
    add_job(1, 5, 2, 0);
    drain("stall", 600);
    chk("stall_aborts", 64'(n_abort - b_abort), 64'd1);
    chk("stall_words", 64'(n_valid - b_valid), 64'(3 + TAGW));
    timeout_en = 1'b0;

    // zero-length request is never granted
    b_g0 = gcount[0]; b_g1 = gcount[1];
    add_job(0, 0, 0, 0);
    add_job(1, 1, 1, 0);
    repeat (60) @(negedge clk);
    chk("zero_src0_grants", 64'(gcount[0] - b_g0), 64'd0);
    chk("zero_src1_grants", 64'(gcount[1] - b_g1), 64'd1);
    jq[0].delete(); mlen[0].delete();
    drain("zero", 200);

    // reset in the middle of a frame, then a clean frame
    b_valid = n_valid;
    add_job(0, 20, 20, 1);
    c = 0;
    while (n_valid - b_valid < 3 && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("midrst_reached_xfer", 64'(c >= 300), 64'd0);
    do_reset("midrst");
    b_valid = n_valid; b_last = n_last;
    add_job(0, 2, 2, 0);
    drain("post_rst", 200);
    chk("post_rst_words", 64'(n_valid - b_valid), 64'(2 + TAGW));
    chk("post_rst_lasts", 64'(n_last - b_last), 64'd1);

`ifdef RX_DMA_ARB_FRAME_TAG_EN
    b_valid = n_valid;
    add_job(1, 2, 2, 0);
    drain("tag", 200);
    chk("tag_word", first_word, 64'h8000_0002_1234_5678);
    chk("tag_words", 64'(n_valid - b_valid), 64'd3);
`endif

    // maximum frame length
    b_valid = n_valid; b_last = n_last;
    add_job(1, 16383, 16383, 0);
    drain("maxlen", 20000);
    chk("maxlen_words", 64'(n_valid - b_valid), 64'(16383 + TAGW));
    chk("maxlen_lasts", 64'(n_last - b_last), 64'd1);

    // random traffic: both sources, mixed lengths, gaps and stalls
    timeout_en = 1'b1;
    for (int it = 0; it < 40; it++) begin
      fixed_prio = $urandom_range(1);
      for (int n = 0; n < 2; n++) begin
        int nj = $urandom_range(3);
        for (int j = 0; j < nj; j++) begin
          int l = $urandom_range(6, 1);
          int ns = l;
          if (l > 1 && $urandom_range(7) == 0) ns = $urandom_range(l - 1, 1);
          add_job(n, l, ns, $urandom_range(2));
        end
      end
      drain("rand", 3000);
    end
    timeout_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
